// File: rtl/mux_scan_sequencer_if.sv
// Signal bundle between the mux scan sequencer and the 32:1 mux it drives.
// The sequencer takes the slave view: it receives start/abort and the
// combined mux output, and drives select, bank enables, status and snapshot.
interface mux_scan_sequencer_if;
    logic        start;
    logic        abort;
    logic        y;
    logic [2:0]  s;
    logic [3:0]  en;
    logic        busy;
    logic        done;
    logic [31:0] q;

    modport master (
        output start,
        output abort,
        output y,
        input  s,
        input  en,
        input  busy,
        input  done,
        input  q
    );

    modport slave (
        input  start,
        input  abort,
        input  y,
        output s,
        output en,
        output busy,
        output done,
        output q
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 32:1 mux built from four 8:1 banks with active-low
// enables. A start request walks channels 0..31, holding each channel's
// select and bank enable for SETTLE+1 cycles and sampling the mux output on
// the last of them. Completed scans land in q atomically with a done pulse.
// SETTLE must lie in 0..15; the settle counter is four bits wide.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mux_scan_sequencer_if.slave  bus
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam logic [3:0] EN_NONE    = 4'b1111;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t      r_state;
    logic [4:0]  r_ch;
    logic [3:0]  r_cnt;
    logic [31:0] r_shadow;
    logic [31:0] r_q;
    logic [2:0]  r_s;
    logic [3:0]  r_en;
    logic        r_busy;
    logic        r_done;

    logic [4:0]  w_chNext;
    logic        w_settled;
    logic        w_lastCh;

    // Active-low one-hot enable for a bank: exactly one bit low.
    function automatic logic [3:0] bankEnable(input logic [1:0] bank);
        bankEnable = ~(4'b0001 << bank);
    endfunction

    assign w_chNext  = r_ch + 5'd1;
    assign w_settled = (r_cnt == SETTLE_CNT);
    assign w_lastCh  = (r_ch == 5'd31);

    // Scan FSM; select and enables are registered from the next channel so
    // the enable moves straight from one bank to the next with no overlap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_ch     <= 5'd0;
            r_cnt    <= 4'd0;
            r_shadow <= 32'd0;
            r_q      <= 32'd0;
            r_s      <= 3'd0;
            r_en     <= EN_NONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_state <= ST_SCAN;
                        r_ch    <= 5'd0;
                        r_cnt   <= 4'd0;
                        r_s     <= 3'd0;
                        r_en    <= bankEnable(2'd0);
                        r_busy  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_ch    <= 5'd0;
                        r_cnt   <= 4'd0;
                        r_s     <= 3'd0;
                        r_en    <= EN_NONE;
                        r_busy  <= 1'b0;
                    end else if (!w_settled) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_shadow[r_ch] <= bus.y;
                        r_cnt          <= 4'd0;
                        if (!w_lastCh) begin
                            r_ch <= w_chNext;
                            r_s  <= w_chNext[2:0];
                            r_en <= bankEnable(w_chNext[4:3]);
                        end else begin
                            r_q     <= {bus.y, r_shadow[30:0]};
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_en    <= EN_NONE;
                            r_ch    <= 5'd0;
                            r_s     <= 3'd0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s    = r_s;
    assign bus.en   = r_en;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.q    = r_q;

endmodule
